// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pulls words from a one-cycle-latency synchronous FIFO
// and presents them on a valid/ready stream through a 2-entry skid buffer.
// Run/drain sequencing is handled by a small IDLE/RUN/DRAIN state machine.
module fifo_rd_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_rd_err,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0]   buf_q [2];
  logic [WIDTH-1:0]   buf_d [2];
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               err_q, err_d;

  logic               pop;
  logic [1:0]         base;   // occupancy left after this cycle's pop
  logic [2:0]         occ;    // committed slots: buffered + inflight - pop

  assign m_valid  = (buf_cnt_q != 2'd0);
  assign m_data   = buf_q[0];
  assign pop      = m_valid && m_ready;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign word_cnt = word_cnt_q;

  assign base = buf_cnt_q - 2'(pop);
  assign occ  = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);

  // Reads are gated by reset so nothing is pulled from the FIFO while the
  // controller is being cleared; a read is only issued when a slot is free.
  assign fifo_rd_en = rst_n && (state_q == RUN) && !fifo_empty && (occ < 3'd2);

  // Next-state logic for the run/drain sequencer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                                   state_d = RUN;
        else if (buf_cnt_q == 2'd0 && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer update: pop shifts the head out, a capture appends behind whatever
  // remains, so a simultaneous pop and capture keeps the count unchanged.
  always_comb begin
    buf_d      = buf_q;
    buf_cnt_d  = base;
    inflight_d = fifo_rd_en;
    word_cnt_d = word_cnt_q + CNT_W'(pop);
    err_d      = err_q || fifo_rd_err;
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    if (inflight_q) begin
      if (base == 2'd2) begin
        // Capture with no free slot cannot happen with correct flow control;
        // flag it rather than silently corrupting the stream.
        err_d = 1'b1;
      end else begin
        buf_d[base[0]] = fifo_rdata;
        buf_cnt_d      = base + 2'd1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge rd_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      // NOTE: the buffer storage is reset because its head drives m_data,
      // which must read zero out of reset; it is only two words.
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a queue-based FIFO model with one
// cycle read latency, a scoreboard on the downstream port, a vector table for
// the basic stream and hand-written sequences for the multi-cycle corners.
module tb_fifo_rd_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             rd_clk;
  logic             rst_n;
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_err;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] word_cnt;

  fifo_rd_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rd_err (fifo_rd_err),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .err         (err),
    .word_cnt    (word_cnt)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int pop_cnt  = 0;

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // FIFO model: data appears on fifo_rdata the cycle after a read strobe.
  logic [WIDTH-1:0] fifo_mem [$];
  logic             force_empty;
  assign fifo_empty = force_empty || (fifo_mem.size() == 0);

  always @(posedge rd_clk) begin
    if (fifo_rd_en && fifo_mem.size() != 0) fifo_rdata <= fifo_mem.pop_front();
  end

  // Scoreboard: expected words are pushed when loaded into the FIFO model.
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge rd_clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL sb_unexpected: got m_data=%0h, expected no transfer", m_data);
      end else begin
        check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
        pop_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] w, input bit expect_out);
    fifo_mem.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    en          = 1'b0;
    m_ready     = 1'b0;
    force_empty = 1'b0;
    fifo_rd_err = 1'b0;
    fifo_mem.delete();
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic             en;
    logic             m_ready;
    logic             exp_rd_en;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_busy;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int rd_cnt;
    int pops_before;
    int hit;

    // Stream of 0x11,0x22,0x33 with m_ready high, then en dropped.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    fifo_rdata = '0;
    apply_reset();

    // Reset state.
    @(negedge rd_clk);
    check("rst_m_valid",  32'(m_valid),    0);
    check("rst_rd_en",    32'(fifo_rd_en), 0);
    check("rst_busy",     32'(busy),       0);
    check("rst_err",      32'(err),        0);
    check("rst_word_cnt", 32'(word_cnt),   0);
    check("rst_m_data",   32'(m_data),     0);
    step();

    // Table-driven stream.
    load(8'h11, 1'b1);
    load(8'h22, 1'b1);
    load(8'h33, 1'b1);
    for (int i = 0; i < 9; i++) begin
      en      = vecs[i].en;
      m_ready = vecs[i].m_ready;
      @(negedge rd_clk);
      check($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
      check($sformatf("tbl%0d_valid", i), 32'(m_valid),    32'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_busy", i),  32'(busy),       32'(vecs[i].exp_busy));
      if (vecs[i].exp_valid) check($sformatf("tbl%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
      step();
    end
    check("stream_word_cnt", 32'(word_cnt), 3);
    check("stream_sb_empty", exp_q.size(), 0);

    // Backpressure: 5 words, m_ready low -> only 2 reads, head held stable.
    apply_reset();
    for (int i = 1; i <= 5; i++) load(8'(8'hA0 + i), 1'b1);
    en      = 1'b1;
    m_ready = 1'b0;
    rd_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      if (fifo_rd_en) rd_cnt++;
      if (i >= 3) begin
        check($sformatf("bp_valid%0d", i), 32'(m_valid), 1);
        check($sformatf("bp_hold%0d", i),  32'(m_data),  32'h A1);
      end
      step();
    end
    check("bp_reads", rd_cnt, 2);
    m_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_word_cnt", 32'(word_cnt), 5);

    // Empty FIFO while running: no reads, stays busy, no error.
    apply_reset();
    force_empty = 1'b1;
    load(8'h5A, 1'b0);
    en      = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      check($sformatf("empty_rd_en%0d", i), 32'(fifo_rd_en), 0);
      check($sformatf("empty_valid%0d", i), 32'(m_valid),    0);
      step();
    end
    check("empty_busy", 32'(busy), 1);
    check("empty_err",  32'(err),  0);

    // Drain: en drops in the cycle a read issues with one word buffered.
    apply_reset();
    load(8'hC0, 1'b1);
    en      = 1'b1;
    m_ready = 1'b0;
    step();
    step();
    step();
    load(8'hC1, 1'b1);
    load(8'hC2, 1'b0);
    en = 1'b0;
    @(negedge rd_clk);
    check("drain_rd_issue", 32'(fifo_rd_en), 1);
    check("drain_buffered", 32'(m_valid),    1);
    step();
    pops_before = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) m_ready = 1'b1;
      @(negedge rd_clk);
      check($sformatf("drain_no_rd%0d", i), 32'(fifo_rd_en), 0);
      step();
    end
    check("drain_delivered", pop_cnt - pops_before, 2);
    check("drain_idle_busy", 32'(busy), 0);
    check("drain_sb_empty",  exp_q.size(), 0);

    // Reset mid-operation: read in flight is dropped, no read under reset.
    apply_reset();
    for (int i = 0; i < 6; i++) load(8'(8'hB0 + i), 1'b0);
    en      = 1'b1;
    m_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge rd_clk);
    check("rst_mid_no_rd", 32'(fifo_rd_en), 0);
    step();
    rst_n = 1'b1;
    @(negedge rd_clk);
    check("rst_mid_valid",    32'(m_valid),  0);
    check("rst_mid_word_cnt", 32'(word_cnt), 0);
    check("rst_mid_busy",     32'(busy),     0);
    step();
    @(negedge rd_clk);
    check("rst_mid_no_capture", 32'(m_valid), 0);
    step();
    for (int i = 1; i < 6; i++) exp_q.push_back(8'(8'hB0 + i));
    en      = 1'b1;
    m_ready = 1'b1;
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) step();
    check("rst_mid_sb_empty", exp_q.size(), 0);
    check("rst_mid_word_cnt2", 32'(word_cnt), 5);

    // Sticky error plus counter wrap at full throughput.
    apply_reset();
    check("err_init", 32'(err), 0);
    for (int i = 0; i < 65536; i++) load(8'(i * 7), 1'b1);
    en          = 1'b1;
    m_ready     = 1'b1;
    fifo_rd_err = 1'b1;
    hit         = -1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge rd_clk);
      if (word_cnt == 16'hFFFF) begin
        hit = i;
        break;
      end
      step();
      fifo_rd_err = 1'b0;
    end
    check("thru_cycles_to_ffff", hit, 65538);
    check("wrap_last_valid",     32'(m_valid), 1);
    step();
    @(negedge rd_clk);
    check("wrap_word_cnt",  32'(word_cnt), 0);
    check("wrap_sb_empty",  exp_q.size(),  0);
    check("err_sticky",     32'(err),      1);
    step();
    apply_reset();
    @(negedge rd_clk);
    check("err_cleared",    32'(err),      0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
